// File: rtl/regfile_write_arbiter_pkg.sv
// Shared processor constants for the write-back path.
// Register geometry and write-back requester IDs.
package regfile_write_arbiter_pkg;

    localparam int REG_SIZE  = 32;
    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;
    localparam int N_REQ     = 3;

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_LSU = 2'd1,
        REQ_MDU = 2'd2
    } req_id_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin selector for write-back requesters.
// Search starts one past the last granted requester.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    // Rotating priority scan, first hit after ptr wins.
    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-back arbiter with pending scoreboard.
// One write per cycle; issue blocked on pending destination.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int REG_SIZE  = regfile_write_arbiter_pkg::REG_SIZE,
    parameter int REG_COUNT = regfile_write_arbiter_pkg::REG_COUNT,
    parameter int N_REQ     = regfile_write_arbiter_pkg::N_REQ
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*REG_IDX_W-1:0]    req_dest,
    input  logic [N_REQ*REG_SIZE-1:0]     req_data,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          issue_valid,
    input  logic [REG_IDX_W-1:0]          issue_dest,
    output logic                          issue_ready,
    input  logic [REG_IDX_W-1:0]          chk_reg_a,
    input  logic [REG_IDX_W-1:0]          chk_reg_b,
    output logic                          chk_stall,
    output logic [REG_COUNT-1:0]          pending,
    output logic                          wr_en,
    output logic [REG_IDX_W-1:0]          wr_reg,
    output logic [REG_SIZE-1:0]           wr_data
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]     grant;
    logic                 xfer;
    logic [REG_IDX_W-1:0] sel_dest;
    logic [REG_SIZE-1:0]  sel_data;
    logic                 issue_fire;
    logic [REG_COUNT-1:0] pending_q, pending_d;
    logic                 wr_en_q, wr_en_d;
    logic [REG_IDX_W-1:0] wr_reg_q;
    logic [REG_SIZE-1:0]  wr_data_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    // One-hot mux of the winning requester and its pointer update.
    always_comb begin
        sel_dest = '0;
        sel_data = '0;
        ptr_d    = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_dest = sel_dest | req_dest[i*REG_IDX_W +: REG_IDX_W];
                sel_data = sel_data | req_data[i*REG_SIZE +: REG_SIZE];
                ptr_d    = PTR_W'(i);
            end
        end
    end

    assign issue_ready = (issue_dest == '0) || !pending_q[issue_dest];
    assign issue_fire  = issue_valid && issue_ready;
    assign chk_stall   = pending_q[chk_reg_a] | pending_q[chk_reg_b];
    assign wr_en_d     = xfer && (sel_dest != '0);

    // Scoreboard: retire on write-back, then claim on issue.
    always_comb begin
        pending_d = pending_q;
        if (xfer && sel_dest != '0) begin
            pending_d[sel_dest] = 1'b0;
        end
        if (issue_fire && issue_dest != '0) begin
            pending_d[issue_dest] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers: pointer, scoreboard and write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= PTR_W'(N_REQ - 1);
            pending_q <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            wr_en_q   <= wr_en_d;
            if (xfer) begin
                wr_reg_q  <= sel_dest;
                wr_data_q <= sel_data;
            end
        end
    end

    assign pending = pending_q;
    assign wr_en   = wr_en_q;
    assign wr_reg  = wr_reg_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for the write-back arbiter.
// Inputs change on negedge; outputs sampled off-edge.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [14:0] req_dest;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_ready;
    logic [4:0]  chk_reg_a;
    logic [4:0]  chk_reg_b;
    logic        chk_stall;
    logic [31:0] pending;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_dest    (req_dest),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_ready (issue_ready),
        .chk_reg_a   (chk_reg_a),
        .chk_reg_b   (chk_reg_b),
        .chk_stall   (chk_stall),
        .pending     (pending),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [4:0] d,
                           input logic [31:0] v);
        req_dest[5*idx +: 5]  = d;
        req_data[32*idx +: 32] = v;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] dat [3];
    logic [4:0]  dst [3];

    initial begin
        rst_n       = 1'b0;
        req_valid   = 3'b111;
        req_dest    = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_dest  = 5'd0;
        chk_reg_a   = 5'd0;
        chk_reg_b   = 5'd0;
        dst[0] = 5'd1; dat[0] = 32'hA000_0001;
        dst[1] = 5'd2; dat[1] = 32'hB000_0002;
        dst[2] = 5'd3; dat[2] = 32'hC000_0003;
        for (int i = 0; i < 3; i++) set_req(i, dst[i], dat[i]);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_reg", wr_reg, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_pending", pending, 0);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_chk_stall", chk_stall, 0);
        chk("rst_req_ready", req_ready, 3'b001);

        // round robin, all valid for six cycles
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr_ready%0d", i), req_ready, 3'b001 << (i % 3));
            after_edge();
            chk($sformatf("rr_wr_en%0d", i), wr_en, 1);
            chk($sformatf("rr_wr_reg%0d", i), wr_reg, dst[i % 3]);
            chk($sformatf("rr_wr_data%0d", i), wr_data, dat[i % 3]);
            @(negedge clk);
        end
        req_valid = 3'b000;
        chk("rr_pending_clear", pending, 0);
        after_edge();
        chk("idle_wr_en", wr_en, 0);

        // WAW protection on reg 8
        @(negedge clk);
        issue_valid = 1'b1;
        issue_dest  = 5'd8;
        #1;
        chk("issue8_ready", issue_ready, 1);
        after_edge();
        chk("issue8_pending", pending, 32'h0000_0100);
        #1;
        chk("issue8_again_ready", issue_ready, 0);
        @(negedge clk);
        after_edge();
        chk("issue8_blocked_pend", pending, 32'h0000_0100);
        @(negedge clk);
        issue_valid = 1'b0;
        set_req(1, 5'd8, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        #1;
        chk("wr8_ready", req_ready, 3'b010);
        after_edge();
        chk("wr8_wr_en", wr_en, 1);
        chk("wr8_wr_reg", wr_reg, 8);
        chk("wr8_wr_data", wr_data, 32'hDEAD_BEEF);
        chk("wr8_pending", pending, 0);
        chk("wr8_issue_ready", issue_ready, 1);

        // operand hazard on reg 5
        @(negedge clk);
        req_valid   = 3'b000;
        issue_valid = 1'b1;
        issue_dest  = 5'd5;
        after_edge();
        @(negedge clk);
        issue_valid = 1'b0;
        chk_reg_a   = 5'd5;
        chk_reg_b   = 5'd0;
        #1;
        chk("haz5_stall", chk_stall, 1);
        set_req(0, 5'd5, 32'h5555_0005);
        req_valid = 3'b001;
        #1;
        chk("haz5_ready", req_ready, 3'b001);
        after_edge();
        chk("haz5_stall_clear", chk_stall, 0);
        chk("haz5_wr_reg", wr_reg, 5);

        // write to reg 0 is accepted but dropped
        @(negedge clk);
        req_valid   = 3'b000;
        issue_valid = 1'b1;
        issue_dest  = 5'd9;
        after_edge();
        @(negedge clk);
        issue_valid = 1'b0;
        set_req(2, 5'd0, 32'h0000_1234);
        req_valid = 3'b100;
        #1;
        chk("r0_ready", req_ready, 3'b100);
        after_edge();
        chk("r0_wr_en", wr_en, 0);
        chk("r0_pending", pending, 32'h0000_0200);

        // issue reg 3 while reg 7 retires
        @(negedge clk);
        req_valid   = 3'b000;
        issue_valid = 1'b1;
        issue_dest  = 5'd7;
        after_edge();
        chk("iss7_pending", pending, 32'h0000_0280);
        @(negedge clk);
        issue_dest = 5'd3;
        set_req(0, 5'd7, 32'h7777_0007);
        req_valid = 3'b001;
        #1;
        chk("same_cyc_ready", req_ready, 3'b001);
        after_edge();
        chk("same_cyc_pending", pending, 32'h0000_0208);
        chk("same_cyc_wr_reg", wr_reg, 7);

        // async reset right after a transfer
        @(negedge clk);
        issue_valid = 1'b0;
        set_req(1, 5'd4, 32'h4444_0004);
        req_valid = 3'b010;
        after_edge();
        chk("pre_rst_wr_en", wr_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_wr_en", wr_en, 0);
        chk("async_pending", pending, 0);
        chk("async_wr_reg", wr_reg, 0);
        @(negedge clk);
        req_valid = 3'b000;
        rst_n     = 1'b1;
        after_edge();
        chk("post_rst_wr_en", wr_en, 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) set_req(i, dst[i], dat[i]);
        req_valid = 3'b111;
        #1;
        chk("post_rst_ready", req_ready, 3'b001);
        after_edge();
        chk("post_rst_wr_reg", wr_reg, dst[0]);
        chk("post_rst_wr_data", wr_data, dat[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
